// File: rtl/irq_request_latch_pkg.sv
// ---------------------------------------------------------------------------
// irq_request_latch_pkg
// Shared constants and helpers for the interrupt request latch.
//   N_SRC      number of request sources
//   IDX_W      width of the source index returned by the encoder
//   MODE_*     values for the EDGE_MODE parameter
//   SETTLE_W   width of the post-reset settle down-counter
// ---------------------------------------------------------------------------
package irq_request_latch_pkg;

    localparam int N_SRC    = 4;
    localparam int IDX_W    = 2;
    localparam int SETTLE_W = 3;

    localparam bit MODE_LEVEL = 1'b0;
    localparam bit MODE_EDGE  = 1'b1;

    typedef logic [N_SRC-1:0] src_vec_t;

    // One-hot decode of an encoder index into a per-source vector.
    function automatic src_vec_t idx_to_vec(input logic [IDX_W-1:0] idx);
        src_vec_t v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/irq_request_latch_bit_sync.sv
// ---------------------------------------------------------------------------
// irq_request_latch_bit_sync
// Single-bit synchroniser: STAGES-deep flop chain with async active-low reset.
// Ports:
//   i_clk    clock
//   i_rst_n  asynchronous active-low reset, clears the whole chain
//   i_d      asynchronous input
//   o_q      synchronised output (last stage)
// ---------------------------------------------------------------------------
module irq_request_latch_bit_sync #(
    parameter int STAGES = 2
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_d,
    output logic o_q
);

    logic [STAGES-1:0] r_chain;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_chain <= '0;
        end else begin
            r_chain <= {r_chain[STAGES-2:0], i_d};
        end
    end

    assign o_q = r_chain[STAGES-1];

endmodule

// File: rtl/irq_request_latch.sv
// ---------------------------------------------------------------------------
// irq_request_latch
// Front end of the 4-input priority encoder. Synchronises four async request
// lines, latches rising edges into pending flags (or follows the level),
// tracks overruns, and drives masked encoder inputs d0..d3. The consumer acks
// the encoder index to clear one pending flag.
// Ports:
//   i_clk       clock, all state on rising edge
//   i_rst_n     asynchronous active-low reset
//   i_irq_in    async request lines, bit i = source i
//   i_mask      1 = source gated from the encoder (still latches)
//   i_ack       one-cycle pulse, consumer serviced i_ack_idx
//   i_ack_idx   index being acked ({a,b} from the encoder)
//   i_ovr_clr   one-cycle pulse, clears all overrun flags
//   o_d0..o_d3  encoder inputs, pending & ~mask
//   o_pending   raw pending flags
//   o_overrun   sticky overrun flags
// ---------------------------------------------------------------------------
module irq_request_latch
    import irq_request_latch_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter bit EDGE_MODE   = MODE_EDGE
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic [N_SRC-1:0] i_irq_in,
    input  logic [N_SRC-1:0] i_mask,
    input  logic             i_ack,
    input  logic [IDX_W-1:0] i_ack_idx,
    input  logic             i_ovr_clr,
    output logic             o_d0,
    output logic             o_d1,
    output logic             o_d2,
    output logic             o_d3,
    output logic [N_SRC-1:0] o_pending,
    output logic [N_SRC-1:0] o_overrun
);

    src_vec_t              w_sync;
    src_vec_t              r_sync_d;
    src_vec_t              r_pending;
    src_vec_t              r_overrun;
    src_vec_t              w_rise;
    src_vec_t              w_ack_vec;
    src_vec_t              w_pending_nxt;
    src_vec_t              w_overrun_nxt;
    src_vec_t              w_d;
    logic [SETTLE_W-1:0]   r_settle;
    logic                  w_armed;

    for (genvar g = 0; g < N_SRC; g++) begin : g_sync
        irq_request_latch_bit_sync #(
            .STAGES (SYNC_STAGES)
        ) u_bit_sync (
            .i_clk   (i_clk),
            .i_rst_n (i_rst_n),
            .i_d     (i_irq_in[g]),
            .o_q     (w_sync[g])
        );
    end

    // After reset release the sync chain refills from whatever level the
    // lines hold. Edge detection stays disarmed until that fill has passed
    // through the history register, so a line held high across reset is not
    // mistaken for a fresh request.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_settle <= SETTLE_W'(SYNC_STAGES + 1);
        end else if (r_settle != '0) begin
            r_settle <= r_settle - SETTLE_W'(1);
        end
    end

    assign w_armed = (r_settle == '0);

    always_comb begin
        w_ack_vec     = '0;
        w_rise        = w_sync & ~r_sync_d & {N_SRC{w_armed}};
        w_pending_nxt = r_pending;
        w_overrun_nxt = r_overrun;

        if (i_ack) begin
            w_ack_vec = idx_to_vec(i_ack_idx);
        end

        if (EDGE_MODE == MODE_EDGE) begin
            // A rise always wins over an ack of the same source, so a new
            // event arriving as the old one is serviced is kept. That case is
            // not an overrun because the earlier event was consumed.
            w_pending_nxt = w_rise | (r_pending & ~w_ack_vec);
            w_overrun_nxt = (w_rise & r_pending & ~w_ack_vec)
                          | (r_overrun & {N_SRC{~i_ovr_clr}});
        end else begin
            w_pending_nxt = w_sync;
            w_overrun_nxt = '0;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sync_d  <= '0;
            r_pending <= '0;
            r_overrun <= '0;
        end else begin
            r_sync_d  <= w_sync;
            r_pending <= w_pending_nxt;
            r_overrun <= w_overrun_nxt;
        end
    end

    assign w_d       = r_pending & ~i_mask;
    assign o_d0      = w_d[0];
    assign o_d1      = w_d[1];
    assign o_d2      = w_d[2];
    assign o_d3      = w_d[3];
    assign o_pending = r_pending;
    assign o_overrun = r_overrun;

endmodule

// File: tb/tb_irq_request_latch.sv
module tb_irq_request_latch;

    localparam int SE = 2;  // sync depth of edge-mode instance
    localparam int SL = 3;  // sync depth of level-mode instance

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] irq_in;
    logic [3:0] mask;
    logic       ack;
    logic [1:0] ack_idx;
    logic       ovr_clr;

    logic       e_d0, e_d1, e_d2, e_d3;
    logic [3:0] e_pend, e_ovr;
    logic       l_d0, l_d1, l_d2, l_d3;
    logic [3:0] l_pend, l_ovr;

    always #5 clk = ~clk;

    irq_request_latch #(.SYNC_STAGES(SE), .EDGE_MODE(1'b1)) u_edge (
        .i_clk(clk), .i_rst_n(rst_n), .i_irq_in(irq_in), .i_mask(mask),
        .i_ack(ack), .i_ack_idx(ack_idx), .i_ovr_clr(ovr_clr),
        .o_d0(e_d0), .o_d1(e_d1), .o_d2(e_d2), .o_d3(e_d3),
        .o_pending(e_pend), .o_overrun(e_ovr)
    );

    irq_request_latch #(.SYNC_STAGES(SL), .EDGE_MODE(1'b0)) u_lvl (
        .i_clk(clk), .i_rst_n(rst_n), .i_irq_in(irq_in), .i_mask(mask),
        .i_ack(ack), .i_ack_idx(ack_idx), .i_ovr_clr(ovr_clr),
        .o_d0(l_d0), .o_d1(l_d1), .o_d2(l_d2), .o_d3(l_d3),
        .o_pending(l_pend), .o_overrun(l_ovr)
    );

    int errors = 0;
    int checks = 0;

    // Reference model: history of sampled request lines since reset release.
    // Edge k after release captures hist[k]; the synchronised view lags by
    // the sync depth, and edges are only reported once the history is valid.
    logic [3:0] hist [0:2047];
    int         n;
    logic [3:0] m_pend, m_ovr, m_lpend;

    function automatic logic [3:0] samp(input int k);
        if (k >= 1) return hist[k];
        return 4'b0000;
    endfunction

    task automatic model_clear();
        n       = 0;
        m_pend  = '0;
        m_ovr   = '0;
        m_lpend = '0;
    endtask

    task automatic model_step();
        logic [3:0] rise;
        if (!rst_n) begin
            model_clear();
        end else begin
            n++;
            hist[n] = irq_in;
            rise = '0;
            if (n >= SE + 2) rise = samp(n - SE) & ~samp(n - SE - 1);
            for (int i = 0; i < 4; i++) begin
                logic acked;
                acked = ack && (int'(ack_idx) == i);
                if (rise[i]) begin
                    if (m_pend[i] && !acked) m_ovr[i] = 1'b1;
                    else if (ovr_clr) m_ovr[i] = 1'b0;
                    m_pend[i] = 1'b1;
                end else begin
                    if (acked) m_pend[i] = 1'b0;
                    if (ovr_clr) m_ovr[i] = 1'b0;
                end
            end
            m_lpend = samp(n - SL);
        end
    endtask

    function automatic logic [1:0] prio(input logic [3:0] v);
        for (int i = 3; i >= 0; i--) if (v[i]) return 2'(i);
        return 2'd0;
    endfunction

    task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_edge_model();
        chk("edge_pending", e_pend, m_pend);
        chk("edge_overrun", e_ovr, m_ovr);
        chk("edge_d", {e_d3, e_d2, e_d1, e_d0}, m_pend & ~mask);
    endtask

    task automatic check_level_model();
        chk("lvl_pending", l_pend, m_lpend);
        chk("lvl_overrun", l_ovr, 4'b0000);
        chk("lvl_d", {l_d3, l_d2, l_d1, l_d0}, m_lpend & ~mask);
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    task automatic async_reset_and_release(input logic [3:0] hold_irq);
        #2;
        rst_n = 1'b0;
        model_clear();
        #1;
        chk("rst_pending", e_pend, 4'b0000);
        chk("rst_overrun", e_ovr, 4'b0000);
        chk("rst_d", {e_d3, e_d2, e_d1, e_d0}, 4'b0000);
        chk("rst_lvl_pending", l_pend, 4'b0000);
        irq_in  = hold_irq;
        ack     = 1'b0;
        ovr_clr = 1'b0;
        cycle();
        cycle();
        rst_n = 1'b1;
    endtask

    typedef struct {
        logic [3:0] irq;
        logic [3:0] msk;
        logic       ak;
        logic [1:0] idx;
        logic       oclr;
        logic [3:0] pend;
        logic [3:0] ovr;
        logic [3:0] d;
    } vec_t;

    vec_t tbl [31];

    initial begin
        tbl[0]  = '{4'b0100, 4'b0000, 1'b0, 2'd0, 1'b0, 4'b0000, 4'b0000, 4'b0000};
        tbl[1]  = '{4'b0100, 4'b0000, 1'b0, 2'd0, 1'b0, 4'b0000, 4'b0000, 4'b0000};
        tbl[2]  = '{4'b0100, 4'b0000, 1'b0, 2'd0, 1'b0, 4'b0100, 4'b0000, 4'b0100};
        tbl[3]  = '{4'b0100, 4'b0000, 1'b1, 2'd2, 1'b0, 4'b0000, 4'b0000, 4'b0000};
        tbl[4]  = '{4'b0100, 4'b0000, 1'b0, 2'd0, 1'b0, 4'b0000, 4'b0000, 4'b0000};
        tbl[5]  = '{4'b1001, 4'b0000, 1'b0, 2'd0, 1'b0, 4'b0000, 4'b0000, 4'b0000};
        tbl[6]  = '{4'b1001, 4'b0000, 1'b0, 2'd0, 1'b0, 4'b0000, 4'b0000, 4'b0000};
        tbl[7]  = '{4'b1001, 4'b0000, 1'b0, 2'd0, 1'b0, 4'b1001, 4'b0000, 4'b1001};
        tbl[8]  = '{4'b1001, 4'b0000, 1'b1, 2'd3, 1'b0, 4'b0001, 4'b0000, 4'b0001};
        tbl[9]  = '{4'b1001, 4'b0000, 1'b1, 2'd0, 1'b0, 4'b0000, 4'b0000, 4'b0000};
        tbl[10] = '{4'b0000, 4'b0000, 1'b0, 2'd0, 1'b0, 4'b0000, 4'b0000, 4'b0000};
        tbl[11] = '{4'b0010, 4'b0000, 1'b0, 2'd0, 1'b0, 4'b0000, 4'b0000, 4'b0000};
        tbl[12] = '{4'b0000, 4'b0000, 1'b0, 2'd0, 1'b0, 4'b0000, 4'b0000, 4'b0000};
        tbl[13] = '{4'b0010, 4'b0000, 1'b0, 2'd0, 1'b0, 4'b0010, 4'b0000, 4'b0010};
        tbl[14] = '{4'b0000, 4'b0000, 1'b0, 2'd0, 1'b0, 4'b0010, 4'b0000, 4'b0010};
        tbl[15] = '{4'b0000, 4'b0000, 1'b0, 2'd0, 1'b0, 4'b0010, 4'b0010, 4'b0010};
        tbl[16] = '{4'b0000, 4'b0000, 1'b0, 2'd0, 1'b1, 4'b0010, 4'b0000, 4'b0010};
        tbl[17] = '{4'b0010, 4'b0000, 1'b0, 2'd0, 1'b0, 4'b0010, 4'b0000, 4'b0010};
        tbl[18] = '{4'b0000, 4'b0000, 1'b0, 2'd0, 1'b0, 4'b0010, 4'b0000, 4'b0010};
        tbl[19] = '{4'b0000, 4'b0000, 1'b1, 2'd1, 1'b0, 4'b0010, 4'b0000, 4'b0010};
        tbl[20] = '{4'b0000, 4'b0000, 1'b1, 2'd1, 1'b0, 4'b0000, 4'b0000, 4'b0000};
        tbl[21] = '{4'b1000, 4'b1000, 1'b0, 2'd0, 1'b0, 4'b0000, 4'b0000, 4'b0000};
        tbl[22] = '{4'b1000, 4'b1000, 1'b0, 2'd0, 1'b0, 4'b0000, 4'b0000, 4'b0000};
        tbl[23] = '{4'b1000, 4'b1000, 1'b0, 2'd0, 1'b0, 4'b1000, 4'b0000, 4'b0000};
        tbl[24] = '{4'b1000, 4'b0000, 1'b0, 2'd0, 1'b0, 4'b1000, 4'b0000, 4'b1000};
        tbl[25] = '{4'b0000, 4'b0000, 1'b0, 2'd0, 1'b0, 4'b1000, 4'b0000, 4'b1000};
        tbl[26] = '{4'b1000, 4'b0000, 1'b0, 2'd0, 1'b0, 4'b1000, 4'b0000, 4'b1000};
        tbl[27] = '{4'b1000, 4'b0000, 1'b0, 2'd0, 1'b0, 4'b1000, 4'b0000, 4'b1000};
        tbl[28] = '{4'b1000, 4'b0000, 1'b0, 2'd0, 1'b1, 4'b1000, 4'b1000, 4'b1000};
        tbl[29] = '{4'b1000, 4'b0000, 1'b1, 2'd2, 1'b0, 4'b1000, 4'b1000, 4'b1000};
        tbl[30] = '{4'b1000, 4'b0000, 1'b1, 2'd3, 1'b1, 4'b0000, 4'b0000, 4'b0000};

        rst_n   = 1'b0;
        irq_in  = '0;
        mask    = '0;
        ack     = 1'b0;
        ack_idx = '0;
        ovr_clr = 1'b0;
        model_clear();

        cycle();
        cycle();
        chk("reset_pending", e_pend, 4'b0000);
        chk("reset_overrun", e_ovr, 4'b0000);
        chk("reset_d", {e_d3, e_d2, e_d1, e_d0}, 4'b0000);
        rst_n = 1'b1;

        for (int i = 0; i < 5; i++) begin
            cycle();
            check_edge_model();
            check_level_model();
        end

        // Directed table: ack clear, same-cycle rises, overrun, ack-vs-rise,
        // masking, ovr_clr-vs-set and acking a non-pending source.
        for (int i = 0; i < 31; i++) begin
            irq_in  = tbl[i].irq;
            mask    = tbl[i].msk;
            ack     = tbl[i].ak;
            ack_idx = tbl[i].idx;
            ovr_clr = tbl[i].oclr;
            cycle();
            chk($sformatf("tbl%0d_pending", i), e_pend, tbl[i].pend);
            chk($sformatf("tbl%0d_overrun", i), e_ovr, tbl[i].ovr);
            chk($sformatf("tbl%0d_d", i), {e_d3, e_d2, e_d1, e_d0}, tbl[i].d);
            check_level_model();
        end
        ack     = 1'b0;
        ovr_clr = 1'b0;

        // Async reset in the middle of a run with pending = 1010, then
        // release with all lines held high: nothing may latch.
        irq_in = 4'b0000;
        for (int i = 0; i < 3; i++) cycle();
        irq_in = 4'b1010;
        for (int i = 0; i < 4; i++) cycle();
        chk("pre_reset_pending", e_pend, 4'b1010);
        async_reset_and_release(4'b1111);
        for (int i = 0; i < 8; i++) begin
            cycle();
            chk("release_no_latch", e_pend, 4'b0000);
            check_level_model();
        end
        check_edge_model();

        // Randomised traffic against the reference model, with the ack index
        // taken from a priority encoder over the expected encoder inputs.
        for (int c = 0; c < 400; c++) begin
            for (int b = 0; b < 4; b++)
                if ($urandom_range(0, 5) == 0) irq_in[b] = ~irq_in[b];
            if ($urandom_range(0, 15) == 0) mask = 4'($urandom_range(0, 15));
            ack = ($urandom_range(0, 2) == 0);
            if ((m_pend & ~mask) != 4'b0000 && $urandom_range(0, 3) != 0)
                ack_idx = prio(m_pend & ~mask);
            else
                ack_idx = 2'($urandom_range(0, 3));
            ovr_clr = ($urandom_range(0, 15) == 0);
            cycle();
            check_edge_model();
            check_level_model();
            if (c == 200) begin
                async_reset_and_release(irq_in);
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
